// File: rtl/vc_port_control.sv
// vc_port_control: input-port controller for the mesh NoC switch.
// Drives push/pop of the external per-VC FIFOs, runs one route-reservation
// FSM per VC, arbitrates route requests toward the switch allocator and
// forwards flits from VCs that hold a route, both round-robin.
module vc_port_control #(
   parameter int VC            = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int TYPE_WIDTH    = 2,
   parameter int REQUEST_WIDTH = 2,
   parameter int VC_WIDTH      = $clog2(VC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [VC-1:0]            valid_in,
   output logic [VC-1:0]            ready_in,
   output logic [VC-1:0]            pushBuffer,
   input  logic [VC-1:0]            full,
   input  logic [VC-1:0]            empty,
   input  logic [VC*DATA_WIDTH-1:0] bufHead,
   output logic [VC-1:0]            popBuffer,
   output logic                     routeReserveRequestValid,
   output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
   output logic [VC_WIDTH-1:0]      routeReserveVC,
   input  logic                     routeReserveStatus,
   output logic                     routeRelieve,
   output logic [VC_WIDTH-1:0]      routeRelieveVC,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic [VC_WIDTH-1:0]      vc_out,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic                     flitError
);

   localparam logic [TYPE_WIDTH-1:0] FLIT_HEAD_TAIL = TYPE_WIDTH'(0);
   localparam logic [TYPE_WIDTH-1:0] FLIT_HEAD      = TYPE_WIDTH'(1);
   localparam logic [TYPE_WIDTH-1:0] FLIT_TAIL      = TYPE_WIDTH'(3);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACTIVE
   } vcState_e;

   vcState_e state     [VC];
   vcState_e stateNext [VC];

   // Round-robin pick: first set bit of elig at or after ptr, wrapping at VC.
   // Returns {found, index}. Scanning downward lets the nearest offset win.
   function automatic logic [VC_WIDTH:0] rrSelect(input logic [VC-1:0]       elig,
                                                  input logic [VC_WIDTH-1:0] ptr);
      logic [VC_WIDTH:0]   result;
      logic [VC_WIDTH-1:0] idxW;
      int                  idx;
      result = '0;
      for (int i = VC - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= VC) idx = idx - VC;
         idxW = idx[VC_WIDTH-1:0];
         if (elig[idxW]) result = {1'b1, idxW};
      end
      return result;
   endfunction

   // Pointer increment with explicit wrap so non-power-of-2 VC counts work.
   function automatic logic [VC_WIDTH-1:0] wrapInc(input logic [VC_WIDTH-1:0] x);
      return (x == VC_WIDTH'(VC - 1)) ? '0 : x + 1'b1;
   endfunction

   // ---------------------------------------------------------------- head flits
   logic [DATA_WIDTH-1:0] headFlit [VC];
   logic [VC-1:0]         headIsStart;
   logic [VC-1:0]         headIsEnd;

   for (genvar g = 0; g < VC; g++) begin : gHead
      logic [TYPE_WIDTH-1:0] headType;
      assign headFlit[g]    = bufHead[g*DATA_WIDTH +: DATA_WIDTH];
      assign headType       = headFlit[g][DATA_WIDTH-1 -: TYPE_WIDTH];
      assign headIsStart[g] = (headType == FLIT_HEAD) || (headType == FLIT_HEAD_TAIL);
      assign headIsEnd[g]   = (headType == FLIT_TAIL) || (headType == FLIT_HEAD_TAIL);
   end

   // ------------------------------------------------------------------ ingress
   // Pushes are suppressed during reset because the FIFOs clear on the same rst.
   assign ready_in   = ~full;
   assign pushBuffer = valid_in & ~full & {VC{~rst}};

   // Decode per-VC state into eligibility vectors for the two arbiters.
   logic [VC-1:0] isIdle;
   logic [VC-1:0] isReq;
   logic [VC-1:0] isActive;

   // NOTE: every variable written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      isIdle   = '0;
      isReq    = '0;
      isActive = '0;
      for (int v = 0; v < VC; v++) begin
         isIdle[v]   = (state[v] == IDLE);
         isReq[v]    = (state[v] == REQ);
         isActive[v] = (state[v] == ACTIVE);
      end
   end

   // ----------------------------------------------------------- request arbiter
   logic                reqFound;
   logic [VC_WIDTH-1:0] reqPick;
   logic [VC_WIDTH-1:0] reqPtr;
   logic                reqGrant;

   assign {reqFound, reqPick} = rrSelect(isReq, reqPtr);
   assign reqGrant            = routeReserveRequestValid & routeReserveStatus;

   // One outstanding request: register a new one when idle, hold it until granted.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         routeReserveRequestValid <= 1'b0;
         routeReserveRequest      <= '0;
         routeReserveVC           <= '0;
         reqPtr                   <= '0;
      end else if (reqGrant) begin
         routeReserveRequestValid <= 1'b0;
         reqPtr                   <= wrapInc(routeReserveVC);
      end else if (!routeReserveRequestValid && reqFound) begin
         routeReserveRequestValid <= 1'b1;
         routeReserveRequest      <= headFlit[reqPick][REQUEST_WIDTH-1:0];
         routeReserveVC           <= reqPick;
      end
   end

   // ------------------------------------------------------------ egress arbiter
   logic                egFound;
   logic [VC_WIDTH-1:0] egPick;
   logic [VC_WIDTH-1:0] egPtr;
   logic [VC_WIDTH-1:0] egSel;
   logic                egHold;
   logic [VC_WIDTH-1:0] egHoldSel;
   logic                egValid;
   logic                egPop;
   logic                egEnd;

   assign {egFound, egPick} = rrSelect(isActive & ~empty, egPtr);
   // A stalled offer stays on the same VC even if a nearer VC becomes eligible.
   assign egSel   = egHold ? egHoldSel : egPick;
   assign egValid = (egHold | egFound) & ~rst;
   assign egPop   = egValid & ready_out;
   assign egEnd   = headIsEnd[egSel];

   assign valid_out = egValid;
   assign data_out  = egValid ? headFlit[egSel] : '0;
   assign vc_out    = egValid ? egSel : '0;

   // Freeze the offered VC under back-pressure, advance the pointer on a pop,
   // and emit the route-release pulse one cycle after a packet-ending pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         egHold         <= 1'b0;
         egHoldSel      <= '0;
         egPtr          <= '0;
         routeRelieve   <= 1'b0;
         routeRelieveVC <= '0;
      end else begin
         egHold       <= egValid & ~ready_out;
         egHoldSel    <= egSel;
         routeRelieve <= egPop & egEnd;
         if (egPop) begin
            egPtr <= wrapInc(egSel);
            if (egEnd) routeRelieveVC <= egSel;
         end
      end
   end

   // ---------------------------------------------------------- error flushing
   logic                errFound;
   logic [VC_WIDTH-1:0] errSel;

   // Lowest-index IDLE VC whose head is not a packet start gets flushed.
   always_comb begin
      errFound = 1'b0;
      errSel   = '0;
      for (int v = VC - 1; v >= 0; v--) begin
         if (isIdle[v] && !empty[v] && !headIsStart[v]) begin
            errFound = 1'b1;
            errSel   = VC_WIDTH'(v);
         end
      end
   end

   // Single pop per cycle: the egress pop wins, an error flush waits a cycle.
   always_comb begin
      popBuffer = '0;
      flitError = 1'b0;
      if (egPop) begin
         popBuffer[egSel] = 1'b1;
      end else if (errFound && !rst) begin
         popBuffer[errSel] = 1'b1;
         flitError         = 1'b1;
      end
   end

   // ------------------------------------------------------------- VC FSMs
   // Next state for every VC: start a request, take a grant, close on packet end.
   always_comb begin
      for (int v = 0; v < VC; v++) begin
         stateNext[v] = state[v];
         case (state[v])
            IDLE:    if (!empty[v] && headIsStart[v]) stateNext[v] = REQ;
            REQ:     if (reqGrant && routeReserveVC == VC_WIDTH'(v)) stateNext[v] = ACTIVE;
            ACTIVE:  if (egPop && egEnd && egSel == VC_WIDTH'(v)) stateNext[v] = IDLE;
            default: stateNext[v] = IDLE;
         endcase
      end
   end

   // State register for all VC FSMs.
   always_ff @(posedge clk) begin
      for (int v = 0; v < VC; v++) begin
         if (rst) state[v] <= IDLE;
         else     state[v] <= stateNext[v];
      end
   end

endmodule

// File: tb/tb_vc_port_control.sv
// Self-checking bench for vc_port_control: a FIFO model per VC behind the
// DUT, scoreboards for route requests, egress flits and route releases.
module tb_vc_port_control;

   localparam int VC    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 8;

   localparam logic [1:0] T_HT = 2'd0;
   localparam logic [1:0] T_H  = 2'd1;
   localparam logic [1:0] T_B  = 2'd2;
   localparam logic [1:0] T_T  = 2'd3;

   typedef struct packed {
      logic [1:0]  vc;
      logic [31:0] data;
   } egEntry_t;

   typedef struct packed {
      logic [1:0] dir;
      logic [1:0] vc;
   } reqEntry_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [VC-1:0] valid_in;
   logic [VC-1:0] ready_in;
   logic [VC-1:0] pushBuffer;
   logic [VC-1:0] full;
   logic [VC-1:0] empty;
   logic [VC*DW-1:0] bufHead;
   logic [VC-1:0] popBuffer;
   logic          routeReserveRequestValid;
   logic [1:0]    routeReserveRequest;
   logic [1:0]    routeReserveVC;
   logic          routeReserveStatus;
   logic          routeRelieve;
   logic [1:0]    routeRelieveVC;
   logic [DW-1:0] data_out;
   logic [1:0]    vc_out;
   logic          valid_out;
   logic          ready_out;
   logic          flitError;

   // Bench-side controls for the FIFO model.
   logic [VC-1:0] hide;
   logic [VC-1:0] fullForce;
   logic [DW-1:0] linkData;
   logic [VC-1:0] errPopExp;

   logic [DW-1:0] fifoMem [VC][DEPTH];
   int            wrPtr [VC];
   int            rdPtr [VC];
   int            count [VC];

   egEntry_t  egQ[$];
   reqEntry_t reqQ[$];
   logic [1:0] vcLog[$];
   logic       relPend;
   logic [1:0] relPendVc;

   int passCount  = 0;
   int checkCount = 0;
   int failCount  = 0;

   logic [1:0] expOrder [6] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};

   vc_port_control #(
      .VC(VC), .DATA_WIDTH(DW), .TYPE_WIDTH(2), .REQUEST_WIDTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .valid_in(valid_in), .ready_in(ready_in), .pushBuffer(pushBuffer),
      .full(full), .empty(empty), .bufHead(bufHead), .popBuffer(popBuffer),
      .routeReserveRequestValid(routeReserveRequestValid),
      .routeReserveRequest(routeReserveRequest), .routeReserveVC(routeReserveVC),
      .routeReserveStatus(routeReserveStatus),
      .routeRelieve(routeRelieve), .routeRelieveVC(routeRelieveVC),
      .data_out(data_out), .vc_out(vc_out), .valid_out(valid_out),
      .ready_out(ready_out), .flitError(flitError)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Per-VC FIFO model fed from the link by pushBuffer and drained by popBuffer.
   always @(posedge clk) begin
      for (int v = 0; v < VC; v++) begin
         if (rst) begin
            wrPtr[v] <= 0;
            rdPtr[v] <= 0;
            count[v] <= 0;
         end else begin
            if (pushBuffer[v]) begin
               fifoMem[v][wrPtr[v]] <= linkData;
               wrPtr[v] <= (wrPtr[v] + 1) % DEPTH;
            end
            if (popBuffer[v]) rdPtr[v] <= (rdPtr[v] + 1) % DEPTH;
            count[v] <= count[v] + int'(pushBuffer[v]) - int'(popBuffer[v]);
         end
      end
   end

   for (genvar g = 0; g < VC; g++) begin : gFifo
      assign full[g]                = fullForce[g] | (count[g] == DEPTH);
      assign empty[g]               = hide[g] | (count[g] == 0);
      assign bufHead[g*DW +: DW]    = fifoMem[g][rdPtr[g]];
   end

   function automatic logic [31:0] mkFlit(input logic [1:0] t, input logic [1:0] dir,
                                          input logic [15:0] payload);
      return {t, 12'h000, payload, dir};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check this cycle's outputs against the scoreboards, then advance one clock.
   task automatic cycle();
      logic       relNext;
      logic [1:0] relNextVc;
      logic [3:0] expReady;
      logic [3:0] expPush;
      logic [3:0] expPop;
      int         idx;
      relNext   = 1'b0;
      relNextVc = 2'd0;
      #1;
      expReady = ~full;
      expPush  = valid_in & ~full;
      check("ready_in", ready_in, expReady);
      check("pushBuffer", pushBuffer, expPush);
      check("routeRelieve", routeRelieve, relPend);
      if (relPend) check("routeRelieveVC", routeRelieveVC, relPendVc);
      if (valid_out === 1'b1 && ready_out) begin
         expPop = 4'b0001 << vc_out;
         check("popBuffer", popBuffer, expPop);
         idx = -1;
         foreach (egQ[i]) if (idx < 0 && egQ[i].vc == vc_out) idx = i;
         check("egressEntryFound", idx >= 0, 1'b1);
         if (idx >= 0) begin
            check("egressData", data_out, egQ[idx].data);
            if (egQ[idx].data[31:30] == T_T || egQ[idx].data[31:30] == T_HT) begin
               relNext   = 1'b1;
               relNextVc = vc_out;
            end
            egQ.delete(idx);
         end
         vcLog.push_back(vc_out);
      end else if (valid_out === 1'b1) begin
         check("popBufferStalled", popBuffer, 4'b0000);
      end else begin
         check("popBuffer", popBuffer, errPopExp);
      end
      check("flitError", flitError, errPopExp != 4'b0000);
      if (routeReserveRequestValid === 1'b1) begin
         check("requestExpected", reqQ.size() > 0, 1'b1);
         if (reqQ.size() > 0) begin
            check("routeReserveRequest", routeReserveRequest, reqQ[0].dir);
            check("routeReserveVC", routeReserveVC, reqQ[0].vc);
            if (routeReserveStatus) void'(reqQ.pop_front());
         end
      end
      @(posedge clk);
      #1;
      relPend   = relNext;
      relPendVc = relNextVc;
   endtask

   // Drive one flit on the link for one cycle.
   task automatic send(input int v, input logic [31:0] flit, input logic expectEgress);
      valid_in = 4'b0001 << v;
      linkData = flit;
      if (!full[v] && expectEgress) egQ.push_back('{vc: 2'(v), data: flit});
      cycle();
      valid_in = '0;
   endtask

   // Run until every scoreboard is empty, within a cycle budget.
   task automatic drain(input string tag, input int maxCycles);
      int n;
      n = 0;
      while ((egQ.size() > 0 || reqQ.size() > 0 || relPend) && n < maxCycles) begin
         cycle();
         n++;
      end
      check(tag, egQ.size() == 0 && reqQ.size() == 0 && !relPend, 1'b1);
   endtask

   task automatic waitValid(input string tag, input int maxCycles);
      int n;
      n = 0;
      while (valid_out !== 1'b1 && n < maxCycles) begin
         cycle();
         n++;
      end
      check(tag, valid_out, 1'b1);
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, ".reqValid"}, routeReserveRequestValid, 1'b0);
      check({tag, ".request"}, routeReserveRequest, 2'd0);
      check({tag, ".reqVC"}, routeReserveVC, 2'd0);
      check({tag, ".relieve"}, routeRelieve, 1'b0);
      check({tag, ".relieveVC"}, routeRelieveVC, 2'd0);
      check({tag, ".flitError"}, flitError, 1'b0);
      check({tag, ".valid_out"}, valid_out, 1'b0);
      check({tag, ".popBuffer"}, popBuffer, 4'b0000);
      check({tag, ".pushBuffer"}, pushBuffer, 4'b0000);
      check({tag, ".vc_out"}, vc_out, 2'd0);
      check({tag, ".data_out"}, data_out, 32'd0);
   endtask

   // Directed sequence.
   initial begin
      logic [31:0] stallHead;
      rst = 1'b1;  valid_in = '0;  linkData = '0;  routeReserveStatus = 1'b0;
      ready_out = 1'b0;  hide = '0;  fullForce = '0;  errPopExp = '0;
      relPend = 1'b0;  relPendVc = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("init");
      rst = 1'b0;

      // Six-flit packet on VC2 toward direction 3.
      ready_out = 1'b1;
      hide[2] = 1'b1;
      send(2, mkFlit(T_H, 2'd3, 16'h2000), 1'b1);
      for (int i = 1; i <= 4; i++) send(2, mkFlit(T_B, 2'd0, 16'(16'h2000 + i)), 1'b1);
      send(2, mkFlit(T_T, 2'd0, 16'h2005), 1'b1);
      reqQ.push_back('{dir: 2'd3, vc: 2'd2});
      hide[2] = 1'b0;
      cycle();
      check("t2.reqLatency1", routeReserveRequestValid, 1'b0);
      cycle();
      check("t2.reqLatency2", routeReserveRequestValid, 1'b1);
      repeat (3) cycle();
      check("t2.noEgressBeforeGrant", valid_out, 1'b0);
      routeReserveStatus = 1'b1;
      cycle();
      drain("t2.drained", 40);

      // Back-pressure: VC1 offer must stay frozen while VC3 becomes eligible.
      ready_out = 1'b0;
      hide[1] = 1'b1;  hide[3] = 1'b1;
      stallHead = mkFlit(T_H, 2'd1, 16'h4100);
      send(1, stallHead, 1'b1);
      send(1, mkFlit(T_T, 2'd0, 16'h4101), 1'b1);
      send(3, mkFlit(T_HT, 2'd0, 16'h4300), 1'b1);
      reqQ.push_back('{dir: 2'd1, vc: 2'd1});
      reqQ.push_back('{dir: 2'd0, vc: 2'd3});
      hide[1] = 1'b0;
      waitValid("t4.validSeen", 20);
      hide[3] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t4.stallValid", valid_out, 1'b1);
         check("t4.stallVc", vc_out, 2'd1);
         check("t4.stallData", data_out, stallHead);
      end
      vcLog.delete();
      ready_out = 1'b1;
      drain("t4.drained", 30);
      check("t4.popCount", vcLog.size(), 3);
      if (vcLog.size() == 3) begin
         check("t4.order0", vcLog[0], 2'd1);
         check("t4.order1", vcLog[1], 2'd3);
         check("t4.order2", vcLog[2], 2'd1);
      end

      // BODY flit at the head of an IDLE VC is flushed and flagged.
      hide[1] = 1'b1;
      send(1, mkFlit(T_B, 2'd0, 16'h5100), 1'b0);
      hide[1] = 1'b0;
      errPopExp = 4'b0010;
      cycle();
      errPopExp = 4'b0000;
      repeat (4) cycle();
      check("t5.noRequest", routeReserveRequestValid, 1'b0);
      check("t5.fifoFlushed", empty[1], 1'b1);

      // HEAD_TAIL on VC0 while its FIFO reports full.
      hide[0] = 1'b1;
      send(0, mkFlit(T_HT, 2'd2, 16'h6000), 1'b1);
      fullForce[0] = 1'b1;
      valid_in = 4'b0001;
      linkData = mkFlit(T_HT, 2'd1, 16'h6001);
      #1;
      check("t6.readyLow", ready_in[0], 1'b0);
      check("t6.noPush", pushBuffer[0], 1'b0);
      cycle();
      valid_in = '0;
      reqQ.push_back('{dir: 2'd2, vc: 2'd0});
      hide[0] = 1'b0;
      drain("t6.drained", 20);
      fullForce[0] = 1'b0;

      // Reset while VC1 is mid-packet: no release pulse, everything cleared.
      ready_out = 1'b0;
      reqQ.push_back('{dir: 2'd2, vc: 2'd1});
      send(1, mkFlit(T_H, 2'd2, 16'h7100), 1'b1);
      send(1, mkFlit(T_B, 2'd0, 16'h7101), 1'b1);
      send(1, mkFlit(T_B, 2'd0, 16'h7102), 1'b1);
      send(1, mkFlit(T_T, 2'd0, 16'h7103), 1'b1);
      waitValid("t1.validSeen", 20);
      ready_out = 1'b1;
      cycle();
      cycle();
      ready_out = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkResetOutputs("midReset");
      egQ.delete();  reqQ.delete();  vcLog.delete();
      relPend = 1'b0;
      rst = 1'b0;
      repeat (3) cycle();
      check("t1.idleAfterReset", valid_out, 1'b0);

      // Simultaneous heads on VC0 and VC3, then interleaved egress.
      hide[0] = 1'b1;  hide[3] = 1'b1;
      send(0, mkFlit(T_H, 2'd1, 16'h8000), 1'b1);
      send(0, mkFlit(T_B, 2'd0, 16'h8001), 1'b1);
      send(0, mkFlit(T_T, 2'd0, 16'h8002), 1'b1);
      send(3, mkFlit(T_H, 2'd2, 16'h8300), 1'b1);
      send(3, mkFlit(T_B, 2'd0, 16'h8301), 1'b1);
      send(3, mkFlit(T_T, 2'd0, 16'h8302), 1'b1);
      reqQ.push_back('{dir: 2'd1, vc: 2'd0});
      reqQ.push_back('{dir: 2'd2, vc: 2'd3});
      routeReserveStatus = 1'b1;
      hide[0] = 1'b0;  hide[3] = 1'b0;
      repeat (6) cycle();
      check("t3.bothGranted", reqQ.size(), 0);
      vcLog.delete();
      ready_out = 1'b1;
      drain("t3.drained", 40);
      check("t3.popCount", vcLog.size(), 6);
      if (vcLog.size() == 6) begin
         for (int i = 0; i < 6; i++) check("t3.order", vcLog[i], expOrder[i]);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/vc_port_control.md
Name: vc_port_control

Overview:
- Next-generation input-port controller for the mesh NoC switch.
- Manages VC independent virtual-channel buffers on one input port:
  - per-VC ingress push control;
  - per-VC route-reservation state machines;
  - round-robin arbitration of route requests toward the switch allocator;
  - round-robin flit forwarding among VCs holding a route.
- Sits between the input link and the crossbar. The VC FIFOs are external; this block drives their push/pop and reads their head flits.

Parameters:
- VC, 4: number of virtual channels, ≥2.
- DATA_WIDTH, 32: flit width in bits.
- TYPE_WIDTH, 2: flit-type field, located at data[DATA_WIDTH-1 -: TYPE_WIDTH].
- REQUEST_WIDTH, 2: output-direction field, located at data[REQUEST_WIDTH-1:0] of head flits.
- VC_WIDTH, $clog2(VC): VC index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  VC  per-VC ingress valid (at most one bit set)
- ready_in  out  VC  per-VC ingress ready
- pushBuffer  out  VC  per-VC FIFO push
- full  in  VC  per-VC FIFO full
- empty  in  VC  per-VC FIFO empty
- bufHead  in  VC*DATA_WIDTH  head flit of each FIFO; VC v occupies [v*DATA_WIDTH +: DATA_WIDTH]
- popBuffer  out  VC  per-VC FIFO pop
- routeReserveRequestValid  out  1  route request valid
- routeReserveRequest  out  REQUEST_WIDTH  requested output direction
- routeReserveVC  out  VC_WIDTH  VC issuing the request
- routeReserveStatus  in  1  grant; accepted when high together with the request valid
- routeRelieve  out  1  one-cycle release pulse
- routeRelieveVC  out  VC_WIDTH  VC releasing its route
- data_out  out  DATA_WIDTH  forwarded flit
- vc_out  out  VC_WIDTH  VC of the forwarded flit
- valid_out  out  1  egress valid
- ready_out  in  1  egress ready
- flitError  out  1  one-cycle pulse when a non-head flit is found at the head of an IDLE VC

Behaviour:
- Reset (synchronous, active-high):
  - all VC FSMs go to IDLE; request and egress round-robin pointers go to 0;
  - routeReserveRequestValid, routeRelieve, flitError, valid_out, popBuffer, pushBuffer = 0;
  - routeReserveRequest, routeReserveVC, routeRelieveVC, vc_out, data_out = 0;
  - routes held before reset are not relieved (the switch resets on the same rst).
- Flit types: 00 HEAD_TAIL (single-flit packet), 01 HEAD, 10 BODY, 11 TAIL.
- Ingress (combinational):
  - ready_in[v] = ~full[v];
  - pushBuffer[v] = valid_in[v] & ~full[v].
- Per-VC FSM states: IDLE, REQ, ACTIVE.
  - IDLE: when ~empty and the head flit type is HEAD or HEAD_TAIL, go to REQ next cycle.
  - IDLE, non-head type at head: pop the flit, pulse flitError, stay in IDLE.
  - REQ: eligible for request arbitration.
  - ACTIVE: eligible for egress arbitration.
- Request arbiter:
  - Only one request is outstanding at a time.
  - When no request is outstanding, the next REQ VC at or after the request pointer is selected.
  - routeReserveRequestValid, routeReserveRequest and routeReserveVC are registered and set the cycle after selection.
  - All three hold stable until routeReserveStatus=1 is sampled.
  - On grant: the VC goes to ACTIVE next cycle, the request valid drops, and the pointer moves to granted VC+1 (mod VC).
  - The arbiter may issue a new request on the following cycle.
- Egress arbiter:
  - Selects an ACTIVE, non-empty VC round-robin. valid_out=1 when one exists.
  - data_out and vc_out come from the selected VC's bufHead (combinational).
  - While valid_out=1 and ready_out=0, the selection is frozen; valid, data and VC must not change.
  - On valid_out & ready_out: popBuffer[sel]=1 that cycle and the pointer moves to sel+1.
- Packet end:
  - Popping a TAIL or HEAD_TAIL flit sends that VC to IDLE next cycle.
  - routeRelieve=1 and routeRelieveVC=sel are registered and asserted one cycle after the pop, for one cycle.
- ACTIVE VC with an empty FIFO stays ACTIVE, keeps its route, and is skipped by the egress arbiter.
- Simultaneous events:
  - A grant for VC a and a tail pop on VC b in the same cycle are both honoured.
  - Push and pop on the same VC in the same cycle are both allowed.
  - At most one popBuffer bit is high per cycle; an error pop and an egress pop never target the same VC.
- Widths: pointers wrap modulo VC. Non-power-of-2 VC wraps explicitly.

Test Plan:
- Reset while VC1 is ACTIVE mid-packet → next cycle all outputs 0 and all VCs IDLE; no routeRelieve pulse.
- VC=4, one 6-flit packet on VC2 with direction 3 → request (3, vc 2) appears 2 cycles after the head reaches the FIFO head; grant; 6 pops; one routeRelieve with VC 2 one cycle after the TAIL pop.
- Heads on VC0 and VC3 in the same cycle, grant always 1 → requests issued to VC0 then VC3; then egress interleaves 0,3,0,3 under ready_out=1.
- ready_out held 0 for 5 cycles with valid_out=1 → data_out and vc_out constant, popBuffer=0 throughout; one pop when ready rises.
- BODY flit at the head of an IDLE VC1 → popBuffer[1] and flitError pulse for one cycle; no request issued.
- HEAD_TAIL flit on VC0 with full[0]=1 and ingress valid → ready_in[0]=0 and no push; after the grant, one pop followed by a routeRelieve pulse.
